// File: rtl/boreal_ledger_pkg.sv
// Purpose : shared types and constants for the boreal audit ledger.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: read-status codes, entry width, entry field offsets and the entry
//           word-fold helper used by the chain digest.
package boreal_ledger_pkg;

    localparam int LEDGER_ENTRY_W = 256;
    localparam int LEDGER_WORD_W  = 32;

    // Bit offsets of the eight 32-bit fields inside a ledger entry.
    localparam int LEDGER_OFF_CYCLE       = 0;
    localparam int LEDGER_OFF_NONCE       = 32;
    localparam int LEDGER_OFF_OPCODE      = 64;
    localparam int LEDGER_OFF_TARGET      = 96;
    localparam int LEDGER_OFF_APPLIED0    = 128;
    localparam int LEDGER_OFF_COMMITTED   = 160;
    localparam int LEDGER_OFF_CTX_HASH    = 192;
    localparam int LEDGER_OFF_POLICY_HASH = 224;

    typedef enum logic [1:0] {
        LEDGER_RD_OK          = 2'd0,
        LEDGER_RD_EVICTED     = 2'd1,
        LEDGER_RD_NOT_WRITTEN = 2'd2
    } ledger_rd_status_e;

    // XOR of all eight entry fields; order is irrelevant, offsets keep it
    // tied to the documented layout.
    function automatic logic [LEDGER_WORD_W-1:0] ledger_fold(
        input logic [LEDGER_ENTRY_W-1:0] entry
    );
        return entry[LEDGER_OFF_CYCLE       +: LEDGER_WORD_W]
             ^ entry[LEDGER_OFF_NONCE       +: LEDGER_WORD_W]
             ^ entry[LEDGER_OFF_OPCODE      +: LEDGER_WORD_W]
             ^ entry[LEDGER_OFF_TARGET      +: LEDGER_WORD_W]
             ^ entry[LEDGER_OFF_APPLIED0    +: LEDGER_WORD_W]
             ^ entry[LEDGER_OFF_COMMITTED   +: LEDGER_WORD_W]
             ^ entry[LEDGER_OFF_CTX_HASH    +: LEDGER_WORD_W]
             ^ entry[LEDGER_OFF_POLICY_HASH +: LEDGER_WORD_W];
    endfunction

endpackage

// File: rtl/boreal_ledger_chain.sv
// Purpose : one combinational step of the ledger chain digest.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : digest_i current digest, entry_i accepted entry, idx_i index of
//           that entry, digest_o = rotl5(digest_i) ^ fold(entry_i) ^ idx_i.
module boreal_ledger_chain
    import boreal_ledger_pkg::*;
(
    input  logic [31:0]               digest_i,
    input  logic [LEDGER_ENTRY_W-1:0] entry_i,
    input  logic [31:0]               idx_i,
    output logic [31:0]               digest_o
);

    assign digest_o = {digest_i[26:0], digest_i[31:27]} ^ ledger_fold(entry_i) ^ idx_i;

endmodule

// File: rtl/boreal_ledger.sv
// Purpose : append-only audit ledger with DEPTH-entry ring, chain digest and indexed audit reads.
// Latency : writes take effect on the strobe edge; read response registered, 1 cycle after rd_req.
// Backpressure: none; one write and one read may be presented every cycle.
// Ports   : clk/rst_n; ledger_wr_en/ledger_wr_data write port; ledger_idx index of the next
//           accepted write; rd_req/rd_idx -> rd_ack/rd_data/rd_status audit read; head_digest,
//           full, overflow status.
// Config  : BOREAL_LEDGER_CHAIN_EN enables the running digest; otherwise head_digest is 0.
module boreal_ledger
    import boreal_ledger_pkg::*;
#(
    parameter int          DEPTH        = 64,
    parameter bit          LOCK_ON_FULL = 1'b0,
    parameter logic [31:0] CHAIN_SEED   = 32'hB0EA_1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ledger_wr_en,
    input  logic [LEDGER_ENTRY_W-1:0] ledger_wr_data,
    output logic [31:0]               ledger_idx,
    input  logic                      rd_req,
    input  logic [31:0]               rd_idx,
    output logic                      rd_ack,
    output logic [LEDGER_ENTRY_W-1:0] rd_data,
    output logic [1:0]                rd_status,
    output logic [31:0]               head_digest,
    output logic                      full,
    output logic                      overflow
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic [31:0] ledger_idx_q, ledger_idx_d;
    logic        overflow_q, overflow_d;
    logic        wr_drop;
    logic        wr_accept;

    // The index never wraps: a wrapped index would make old absolute
    // indices alias new entries.
    assign wr_drop   = (LOCK_ON_FULL && (ledger_idx_q == DEPTH_W))
                     || (ledger_idx_q == 32'hFFFF_FFFF);
    assign wr_accept = ledger_wr_en && !wr_drop;

    always_comb begin
        ledger_idx_d = ledger_idx_q;
        overflow_d   = overflow_q;
        if (ledger_wr_en) begin
            if (wr_drop) begin
                overflow_d = 1'b1;
            end else begin
                ledger_idx_d = ledger_idx_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledger_idx_q <= 32'd0;
            overflow_q   <= 1'b0;
        end else begin
            ledger_idx_q <= ledger_idx_d;
            overflow_q   <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry RAM: plain array, no reset, synchronous read port, so it maps
    // straight onto a 1W1R SRAM macro. Stale contents after reset are
    // harmless because every index >= ledger_idx reads NOT_WRITTEN.
    // ------------------------------------------------------------------
    logic [LEDGER_ENTRY_W-1:0] mem [DEPTH];
    logic [LEDGER_ENTRY_W-1:0] rd_mem_q;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[ledger_idx_q[AW-1:0]] <= ledger_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_req) begin
            rd_mem_q <= mem[rd_idx[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Read status, decided against the pre-edge index.
    // ------------------------------------------------------------------
    ledger_rd_status_e rd_status_d, rd_status_q;
    logic              rd_ack_q;

    always_comb begin
        rd_status_d = LEDGER_RD_OK;
        if (rd_idx >= ledger_idx_q) begin
            rd_status_d = LEDGER_RD_NOT_WRITTEN;
        end else if (!LOCK_ON_FULL && (ledger_idx_q > DEPTH_W)
                     && (rd_idx < (ledger_idx_q - DEPTH_W))) begin
            rd_status_d = LEDGER_RD_EVICTED;
        end else if (wr_accept && (rd_idx[AW-1:0] == ledger_idx_q[AW-1:0])) begin
            // The oldest live entry is being overwritten on this very edge;
            // report it gone rather than rely on RAM read-during-write order.
            rd_status_d = LEDGER_RD_EVICTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack_q    <= 1'b0;
            rd_status_q <= LEDGER_RD_NOT_WRITTEN;
        end else begin
            rd_ack_q    <= rd_req;
            rd_status_q <= rd_req ? rd_status_d : LEDGER_RD_NOT_WRITTEN;
        end
    end

    // rd_mem_q has no reset; the status gate keeps rd_data at 0 out of
    // reset and for every non-OK response.
    assign rd_ack    = rd_ack_q;
    assign rd_status = rd_status_q;
    assign rd_data   = (rd_status_q == LEDGER_RD_OK) ? rd_mem_q : '0;

    // ------------------------------------------------------------------
    // Chain digest
    // ------------------------------------------------------------------
`ifdef BOREAL_LEDGER_CHAIN_EN
    logic [31:0] digest_q;
    logic [31:0] digest_d;

    boreal_ledger_chain u_chain (
        .digest_i (digest_q),
        .entry_i  (ledger_wr_data),
        .idx_i    (ledger_idx_q),
        .digest_o (digest_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digest_q <= CHAIN_SEED;
        end else if (wr_accept) begin
            digest_q <= digest_d;
        end
    end

    assign head_digest = digest_q;
`else
    // Constant zero; the seed only appears here to keep the parameter bound.
    assign head_digest = CHAIN_SEED & 32'h0;
`endif

    assign ledger_idx = ledger_idx_q;
    assign full       = (ledger_idx_q >= DEPTH_W);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_boreal_ledger.sv
// Bench for boreal_ledger: two instances (overwrite-oldest and lock-on-full)
// share one stimulus stream; read responses are checked by a scoreboard.
module tb_boreal_ledger;
    import boreal_ledger_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [255:0] wr_data;
    logic         rd_req;
    logic [31:0]  rd_idx;

    logic [31:0]  ow_idx, lk_idx;
    logic         ow_ack, lk_ack;
    logic [255:0] ow_data, lk_data;
    logic [1:0]   ow_st, lk_st;
    logic [31:0]  ow_dig, lk_dig;
    logic         ow_full, lk_full;
    logic         ow_ovf, lk_ovf;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [1:0] OK = LEDGER_RD_OK;
    localparam logic [1:0] EV = LEDGER_RD_EVICTED;
    localparam logic [1:0] NW = LEDGER_RD_NOT_WRITTEN;

`ifdef BOREAL_LEDGER_CHAIN_EN
    localparam logic [31:0] DIG_RESET  = 32'hB0EA_1000;
    localparam logic [31:0] DIG_AFTER0 = 32'h1D42_0016; // rotl5(seed) ^ 0 ^ 0
`else
    localparam logic [31:0] DIG_RESET  = 32'h0;
    localparam logic [31:0] DIG_AFTER0 = 32'h0;
`endif

    boreal_ledger #(.DEPTH(64), .LOCK_ON_FULL(1'b0), .CHAIN_SEED(32'hB0EA_1000)) dut_ow (
        .clk(clk), .rst_n(rst_n), .ledger_wr_en(wr_en), .ledger_wr_data(wr_data),
        .ledger_idx(ow_idx), .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(ow_ack),
        .rd_data(ow_data), .rd_status(ow_st), .head_digest(ow_dig),
        .full(ow_full), .overflow(ow_ovf)
    );

    boreal_ledger #(.DEPTH(64), .LOCK_ON_FULL(1'b1), .CHAIN_SEED(32'hB0EA_1000)) dut_lk (
        .clk(clk), .rst_n(rst_n), .ledger_wr_en(wr_en), .ledger_wr_data(wr_data),
        .ledger_idx(lk_idx), .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(lk_ack),
        .rd_data(lk_data), .rd_status(lk_st), .head_digest(lk_dig),
        .full(lk_full), .overflow(lk_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   st;
        logic [255:0] dat;
    } exp_t;

    exp_t q_ow[$];
    exp_t q_lk[$];

    // Entry 0 is all-zero so the first digest step is easy to hand-check.
    function automatic logic [255:0] entry(input int i);
        logic [255:0] e;
        e = '0;
        if (i != 0) begin
            for (int w = 0; w < 8; w++) begin
                e[w*32 +: 32] = {16'(i), 8'(w), 8'hC3};
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per presented response.
    always @(negedge clk) begin
        exp_t e;
        if (ow_ack === 1'b1) begin
            if (q_ow.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL ow_unexpected_ack: got rd_ack=1 expected none pending");
            end else begin
                e = q_ow.pop_front();
                chk("ow_rd_status", 256'(ow_st), 256'(e.st));
                chk("ow_rd_data", ow_data, e.dat);
            end
        end
        if (lk_ack === 1'b1) begin
            if (q_lk.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL lk_unexpected_ack: got rd_ack=1 expected none pending");
            end else begin
                e = q_lk.pop_front();
                chk("lk_rd_status", 256'(lk_st), 256'(e.st));
                chk("lk_rd_data", lk_data, e.dat);
            end
        end
    end

    // One cycle of stimulus, driven on the falling edge. A write also checks
    // that ledger_idx, seen during the strobe, equals the entry's own index.
    task automatic step(input bit we, input int widx, input bit rr, input int ridx,
                        input logic [1:0] st_ow, input logic [1:0] st_lk);
        exp_t e;
        wr_en   = we;
        wr_data = we ? entry(widx) : '0;
        rd_req  = rr;
        rd_idx  = 32'(ridx);
        if (we) chk("ow_idx_at_strobe", 256'(ow_idx), 256'(32'(widx)));
        if (rr) begin
            e.st = st_ow; e.dat = (st_ow == OK) ? entry(ridx) : '0; q_ow.push_back(e);
            e.st = st_lk; e.dat = (st_lk == OK) ? entry(ridx) : '0; q_lk.push_back(e);
        end
        @(negedge clk);
        wr_en  = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_req = 1'b0; rd_idx = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ow_idx",    256'(ow_idx),  256'(32'd0));
        chk("rst_lk_idx",    256'(lk_idx),  256'(32'd0));
        chk("rst_ow_full",   256'(ow_full), 256'(1'b0));
        chk("rst_ow_ovf",    256'(ow_ovf),  256'(1'b0));
        chk("rst_ow_digest", 256'(ow_dig),  256'(DIG_RESET));
        chk("rst_ow_ack",    256'(ow_ack),  256'(1'b0));
        chk("rst_ow_status", 256'(ow_st),   256'(NW));
        chk("rst_ow_data",   ow_data,       256'd0);
        step(0, 0, 1, 0, NW, NW);

        // A, B, C
        step(1, 0, 0, 0, OK, OK);
        chk("digest_after_entry0", 256'(ow_dig), 256'(DIG_AFTER0));
        step(1, 1, 0, 0, OK, OK);
        step(1, 2, 0, 0, OK, OK);
        chk("ow_idx_after_3", 256'(ow_idx), 256'(32'd3));
        step(0, 0, 1, 1, OK, OK);

        // Same-cycle write and read of index 3, then repeat the read
        step(1, 3, 1, 3, NW, NW);
        step(0, 0, 1, 3, OK, OK);

        // Fill to DEPTH
        for (int i = 4; i < 64; i++) step(1, i, 0, 0, OK, OK);
        chk("ow_full_at_64", 256'(ow_full), 256'(1'b1));
        chk("lk_full_at_64", 256'(lk_full), 256'(1'b1));
        chk("lk_ovf_at_64",  256'(lk_ovf),  256'(1'b0));
        chk("lk_idx_at_64",  256'(lk_idx),  256'(32'd64));

        // 65th write overwrites slot 0 (read of idx 0 same cycle) / is dropped
        step(1, 64, 1, 0, EV, OK);
        chk("lk_idx_65w", 256'(lk_idx), 256'(32'd64));
        chk("lk_ovf_65w", 256'(lk_ovf), 256'(1'b1));
        chk("ow_idx_65w", 256'(ow_idx), 256'(32'd65));

        for (int i = 65; i < 70; i++) step(1, i, 0, 0, OK, OK);
        chk("ow_idx_70w",  256'(ow_idx),  256'(32'd70));
        chk("ow_full_70w", 256'(ow_full), 256'(1'b1));
        chk("ow_ovf_70w",  256'(ow_ovf),  256'(1'b0));
        chk("lk_idx_70w",  256'(lk_idx),  256'(32'd64));
        chk("lk_ovf_70w",  256'(lk_ovf),  256'(1'b1));

        step(0, 0, 1, 5,  EV, OK);
        step(0, 0, 1, 6,  OK, OK);
        step(0, 0, 1, 64, OK, NW);
        step(0, 0, 1, 0,  EV, OK);
        step(0, 0, 1, 70, NW, NW);
        step(0, 0, 1, 69, OK, NW);
        step(0, 0, 0, 0,  OK, OK);

        // Reset mid-operation: stale RAM must be unreachable
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_ow_idx",    256'(ow_idx), 256'(32'd0));
        chk("rst2_lk_ovf",    256'(lk_ovf), 256'(1'b0));
        chk("rst2_lk_full",   256'(lk_full), 256'(1'b0));
        chk("rst2_ow_digest", 256'(ow_dig), 256'(DIG_RESET));
        step(0, 0, 1, 3, NW, NW);
        step(0, 0, 0, 0, OK, OK);

        for (int k = 0; k < 10 && (q_ow.size() != 0 || q_lk.size() != 0); k++) @(negedge clk);
        if (q_ow.size() != 0 || q_lk.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL missing_ack: got %0d/%0d responses outstanding expected 0",
                     q_ow.size(), q_lk.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
